// File: rtl/qracc_pkg.sv
// Shared types and default timing for the QR accelerator SRAM access sequencer.
package qracc_pkg;

    localparam int numRows       = 128;
    localparam int numCols       = 32;
    localparam int sramPchCycles = 1;
    localparam int sramWlCycles  = 2;
    localparam int sramSaCycles  = 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRE     = 3'd1,
        S_WLON    = 3'd2,
        S_SENSE   = 3'd3,
        S_RECOVER = 3'd4
    } sram_seq_state_t;

    // The phase counter counts down to zero, so a phase of N cycles loads N-1.
    function automatic logic [3:0] phase_load(input int cycles);
        return 4'(cycles - 1);
    endfunction

endpackage

// File: rtl/qracc_sram_sequencer_if.sv
// Single-word SRAM request/response handshake between the digital side and the sequencer.
interface qracc_sram_sequencer_if #(
    parameter int numRows = qracc_pkg::numRows,
    parameter int numCols = qracc_pkg::numCols
);
    localparam int AddrW = $clog2(numRows);

    logic               rq_wr_i;
    logic               rq_valid_i;
    logic               rq_ready_o;
    logic               rd_valid_o;
    logic [numCols-1:0] rd_data_o;
    logic [numCols-1:0] wr_data_i;
    logic [AddrW-1:0]   addr_i;

    modport master (
        output rq_wr_i, rq_valid_i, wr_data_i, addr_i,
        input  rq_ready_o, rd_valid_o, rd_data_o
    );

    modport slave (
        input  rq_wr_i, rq_valid_i, wr_data_i, addr_i,
        output rq_ready_o, rd_valid_o, rd_data_o
    );

endinterface

// File: rtl/qracc_wl_decoder.sv
// Row address to one-hot wordline decoder; all-zero when disabled or the row does not exist.
module qracc_wl_decoder #(
    parameter int numRows = qracc_pkg::numRows,
    parameter int AddrW   = $clog2(numRows)
) (
    input  logic [AddrW-1:0]   addr_i,
    input  logic               en_i,
    output logic [numRows-1:0] wl_o
);

    // One-hot decode guarded against addresses past the last row.
    always_comb begin
        wl_o = '0;
        if (en_i && (int'(addr_i) < numRows)) begin
            wl_o[addr_i] = 1'b1;
        end else begin
            wl_o = '0;
        end
    end

endmodule

// File: rtl/qracc_sram_sequencer.sv
// Sequences single-word SRAM reads/writes into precharge, wordline and sense phases.
// Optional write-verify read-back is enabled by defining QRACC_SRAM_WRITE_VERIFY_EN.
module qracc_sram_sequencer #(
    parameter int numRows    = qracc_pkg::numRows,
    parameter int numCols    = qracc_pkg::numCols,
    parameter int PCH_CYCLES = qracc_pkg::sramPchCycles,
    parameter int WL_CYCLES  = qracc_pkg::sramWlCycles,
    parameter int SA_CYCLES  = qracc_pkg::sramSaCycles
) (
    input  logic                         clk,
    input  logic                         rst,
    qracc_sram_sequencer_if.slave        sram_itf,
    input  logic                         mac_busy_i,
    output logic [numRows-1:0]           WL,
    output logic                         PCH,
    output logic [numCols-1:0]           WR_DATA,
    output logic                         WRITE,
    output logic [numCols-1:0]           CSEL,
    output logic                         SAEN,
    input  logic [numCols-1:0]           SA_OUT
`ifdef QRACC_SRAM_WRITE_VERIFY_EN
    ,
    output logic                         verify_err_o
`endif
);
    import qracc_pkg::sram_seq_state_t;
    import qracc_pkg::S_IDLE;
    import qracc_pkg::S_PRE;
    import qracc_pkg::S_WLON;
    import qracc_pkg::S_SENSE;
    import qracc_pkg::S_RECOVER;
    import qracc_pkg::phase_load;

    localparam int         AddrW   = $clog2(numRows);
    localparam logic [3:0] PchLoad = phase_load(PCH_CYCLES);
    localparam logic [3:0] WlLoad  = phase_load(WL_CYCLES);
    localparam logic [3:0] SaLoad  = phase_load(SA_CYCLES);

    sram_seq_state_t    state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               wr_q, wr_d;
    logic               vfy_q, vfy_d;
    logic [AddrW-1:0]   addr_q, addr_d;
    logic [numCols-1:0] data_q, data_d;
    logic [numCols-1:0] rd_data_q, rd_data_d;
    logic               ready_s;
    logic               wl_en_s;
`ifdef QRACC_SRAM_WRITE_VERIFY_EN
    logic               err_q, err_d;
`endif

    assign ready_s = !rst && (state_q == S_IDLE) && !mac_busy_i;

    // State, phase counter and latched request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            wr_q      <= 1'b0;
            vfy_q     <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            rd_data_q <= '0;
`ifdef QRACC_SRAM_WRITE_VERIFY_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            vfy_q     <= vfy_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            rd_data_q <= rd_data_d;
`ifdef QRACC_SRAM_WRITE_VERIFY_EN
            err_q     <= err_d;
`endif
        end
    end

    // Next-state logic; every phase exits when its counter reaches zero.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        vfy_d     = vfy_q;
        addr_d    = addr_q;
        data_d    = data_q;
        rd_data_d = rd_data_q;
`ifdef QRACC_SRAM_WRITE_VERIFY_EN
        err_d     = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (sram_itf.rq_valid_i && ready_s) begin
                    state_d = S_PRE;
                    cnt_d   = PchLoad;
                    wr_d    = sram_itf.rq_wr_i;
                    vfy_d   = 1'b0;
                    addr_d  = sram_itf.addr_i;
                    data_d  = sram_itf.wr_data_i;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PRE: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_WLON;
                    cnt_d   = WlLoad;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_WLON: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (wr_q && !vfy_q) begin
`ifdef QRACC_SRAM_WRITE_VERIFY_EN
                    // Read the row straight back before releasing the array.
                    state_d = S_PRE;
                    cnt_d   = PchLoad;
                    vfy_d   = 1'b1;
`else
                    state_d = S_RECOVER;
                    cnt_d   = 4'd0;
`endif
                end else begin
                    state_d = S_SENSE;
                    cnt_d   = SaLoad;
                end
            end
            S_SENSE: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RECOVER;
                    if (vfy_q) begin
`ifdef QRACC_SRAM_WRITE_VERIFY_EN
                        err_d = err_q || (SA_OUT != data_q);
`else
                        rd_data_d = rd_data_q;
`endif
                    end else begin
                        rd_data_d = SA_OUT;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RECOVER: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    assign wl_en_s = (state_q == S_WLON);
    assign PCH     = (state_q == S_PRE);
    assign SAEN    = (state_q == S_SENSE);
    assign WRITE   = wl_en_s && wr_q && !vfy_q;
    assign WR_DATA = WRITE ? data_q : {numCols{1'b0}};
    assign CSEL    = (wl_en_s || SAEN) ? {numCols{1'b1}} : {numCols{1'b0}};

    assign sram_itf.rq_ready_o = ready_s;
    assign sram_itf.rd_valid_o = (state_q == S_RECOVER) && !wr_q;
    assign sram_itf.rd_data_o  = rd_data_q;
`ifdef QRACC_SRAM_WRITE_VERIFY_EN
    assign verify_err_o = err_q;
`endif

    qracc_wl_decoder #(
        .numRows (numRows),
        .AddrW   (AddrW)
    ) u_wl_decoder (
        .addr_i (addr_q),
        .en_i   (wl_en_s),
        .wl_o   (WL)
    );

endmodule

// File: doc/qracc_sram_sequencer.md
Name: qracc_sram_sequencer

Overview:
- Digital-side SRAM access sequencer sitting directly between the `sram_itf` slave modport and the analog macro's SRAM control pins.
- Converts single-word read/write requests into timed precharge → wordline → sense phases.
- Returns read data through the same handshake interface.
- Yields the array to analog compute: no new request is accepted while the MAC path owns it.

Parameters:
- numRows, 128, wordlines in array.
- numCols, 32, bits per word / bitlines.
- PCH_CYCLES, 1, precharge phase length (1..15).
- WL_CYCLES, 2, wordline-active phase length (1..15).
- SA_CYCLES, 1, sense-amp enable phase length, reads only (1..15).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rq_wr_i  in  1  1 = write, 0 = read
- rq_valid_i  in  1  request valid
- rq_ready_o  out  1  request accepted when ready & valid
- rd_valid_o  out  1  one-cycle pulse; rd_data_o valid
- rd_data_o  out  numCols  read word, held until next read completes
- wr_data_i  in  numCols  write word
- addr_i  in  $clog2(numRows)  row address
- mac_busy_i  in  1  analog compute owns array
- WL  out  numRows  one-hot wordline
- PCH  out  1  bitline precharge, active high
- WR_DATA  out  numCols  write drivers
- WRITE  out  1  write-driver enable
- CSEL  out  numCols  column select
- SAEN  out  1  sense-amp enable
- SA_OUT  in  numCols  sense-amp outputs

Behaviour:
- Reset values: every output is 0, including rd_data_o; state is IDLE.
- Reset mid-operation: WL is all-zero on the next edge and the in-flight request is dropped without any rd_valid_o.
- States: IDLE, PRE, WLON, SENSE, RECOVER. A 4-bit phase counter is loaded on each state entry.
- rq_ready_o = (state == IDLE) && !mac_busy_i, combinational.
- On handshake, rq_wr_i, addr_i and wr_data_i are latched. Later input changes are ignored.
- IDLE → PRE on handshake.
- PRE (PCH=1, PCH_CYCLES cycles) → WLON.
- WLON: WL[addr]=1 and CSEL all-ones for WL_CYCLES cycles. On a write, WRITE=1 and WR_DATA=latched data; otherwise WR_DATA=0.
  - Write: WLON → RECOVER.
  - Read: WLON → SENSE.
- SENSE: SAEN=1 and CSEL all-ones for SA_CYCLES cycles. SA_OUT is captured into rd_data_o on the last SENSE cycle's edge. SENSE → RECOVER.
- RECOVER: 1 cycle, all array controls 0. rd_valid_o=1 here for reads only. RECOVER → IDLE.
- Latency with defaults, handshake at edge 0:
  - Read: PCH cycle 1, WL cycles 2-3, SAEN cycle 4, rd_valid_o cycle 5, ready again cycle 6.
  - Write: PCH 1, WL 2-3, RECOVER 4, ready 5.
- Back-to-back requests are allowed: rq_valid_i held high starts the next access on the first IDLE cycle.
- mac_busy_i rising mid-access does not abort; the access completes and ready stays low until mac_busy_i falls.
- addr ≥ numRows (non-power-of-2 numRows): the access runs full timing with WL all-zero; a read returns SA_OUT as sensed (no row).
- No two of PCH/WL/SAEN are ever high in the same cycle.

Optional Feature:
- Macro: QRACC_SRAM_WRITE_VERIFY_EN.
- When defined:
  - Every write is followed automatically by an internal read of the same address (PRE, WLON, SENSE; no rd_valid_o pulse).
  - SA_OUT is compared against the latched wr_data.
  - On mismatch, new output verify_err_o (1 bit, reset 0) is set and stays sticky until rst.
  - rq_ready_o is held low through the verify read. Default write latency becomes 9 cycles to ready.
- When undefined: no verify read, no verify_err_o port, timing as above.

Decomposition:
- qracc_pkg gains the following (numRows/numCols are already in the package):
  - typedef enum logic [2:0] sram_seq_state_t {S_IDLE, S_PRE, S_WLON, S_SENSE, S_RECOVER}
  - default timing constants sramPchCycles, sramWlCycles, sramSaCycles
- One sub-module: qracc_wl_decoder.
  - Inputs: address, enable.
  - Output: one-hot numRows vector, all-zero when disabled or the address is out of range.

Test Plan:
- Reset held 3 cycles with rq_valid_i=1 → all outputs 0, rq_ready_o=0 during reset, 1 after.
- Write addr=5, data=0xA5A5_1234 → PCH cycle 1; WL[5]=1, WRITE=1, WR_DATA=0xA5A5_1234 in cycles 2-3; rq_ready_o=1 at cycle 5.
- Read addr=5 with SA_OUT model returning 0xA5A5_1234 → SAEN cycle 4; rd_valid_o pulse cycle 5 with rd_data_o=0xA5A5_1234, held afterwards.
- mac_busy_i=1 while rq_valid_i=1 → no handshake and no array activity. Drop mac_busy_i → access starts the next cycle. Raise mac_busy_i at cycle 2 of a read → read completes and rd_valid_o still pulses.
- rst asserted at cycle 3 of a read (WL[7] high) → WL=0 next edge, no rd_valid_o; a subsequent write to addr 0 behaves normally.
- With QRACC_SRAM_WRITE_VERIFY_EN, SA_OUT model flips bit 0 → verify_err_o=1 after a write of 0x1, stays 1 after a later correct write; a correct write with a fresh reset leaves it 0.
